// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and the parity helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Callers zero-extend narrower words; the extra zeros leave the XOR unchanged.
  function automatic logic calc_parity(input logic [8:0] data, input int mode);
    logic x;
    x = ^data;
    case (mode)
      PAR_ODD:  return ~x;
      PAR_EVEN: return x;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock synchronous FIFO with occupancy count; the head word is read combinationally.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter: FIFO-fed FSM serialising LSB-first frames with optional parity.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Overflow,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Done,
  output logic [2:0]                    o_SM_Main,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          uart_clk_edge
);

  localparam logic [15:0] CNT_MAX   = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

  logic [2:0]           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 serial_q, active_q, done_q, edge_q, ovf_q;
  logic                 line_bit, bit_end, pop;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 fifo_full, fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_i   (i_Reset),
    .push_i  (i_Tx_DV),
    .wdata_i (i_Tx_Byte),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_Fifo_Count)
  );

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          par_d   = calc_parity(9'(fifo_head), PARITY);
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == LAST_STOP) begin
            bit_d = '0;
            // Chain straight into the next frame when data is waiting.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_head;
              par_d   = calc_parity(9'(fifo_head), PARITY);
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    line_bit = 1'b1;
    case (state_q)
      ST_START:  line_bit = 1'b0;
      ST_DATA:   line_bit = shift_q[0];
      ST_PARITY: line_bit = par_q;
      default:   line_bit = 1'b1;
    endcase
  end

  // Outputs are registered from the current state, so the line trails o_SM_Main by one cycle.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      edge_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      serial_q <= line_bit;
      active_q <= (state_q != ST_IDLE);
      done_q   <= (state_q == ST_STOP) && bit_end && (bit_q == LAST_STOP);
      edge_q   <= (state_q != ST_IDLE) && bit_end;
      ovf_q    <= i_Tx_DV && fifo_full;
    end
  end

  always_ff @(posedge i_Clock) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign o_Tx_Ready    = !fifo_full;
  assign o_Tx_Overflow = ovf_q;
  assign o_Tx_Active   = active_q;
  assign o_Tx_Serial   = serial_q;
  assign o_Tx_Done     = done_q;
  assign o_SM_Main     = state_q;
  assign uart_clk_edge = edge_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg across 8N1, even/odd parity and 7-bit/2-stop builds.
module tb_uart_tx_cfg;

  localparam int CPB = 87;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv   [4];
  logic [7:0] din8 [3];
  logic [6:0] din7;
  logic       rdy  [4];
  logic       ovf  [4];
  logic       act  [4];
  logic       ser  [4];
  logic       done [4];
  logic       edg  [4];
  logic [2:0] sm   [4];
  logic [2:0] fc0;
  logic [4:0] fc1, fc2, fc3;

  int cyc = 0;
  int edge_cnt [4];
  int done_cnt [4];
  int ovf_cnt  [4];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (edg[i])  edge_cnt[i] <= edge_cnt[i] + 1;
      if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
      if (ovf[i])  ovf_cnt[i]  <= ovf_cnt[i] + 1;
    end
  end

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[0]), .i_Tx_Byte(din8[0]),
    .o_Tx_Ready(rdy[0]), .o_Tx_Overflow(ovf[0]), .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]),
    .o_Tx_Done(done[0]), .o_SM_Main(sm[0]), .o_Fifo_Count(fc0), .uart_clk_edge(edg[0]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[1]), .i_Tx_Byte(din8[1]),
    .o_Tx_Ready(rdy[1]), .o_Tx_Overflow(ovf[1]), .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]),
    .o_Tx_Done(done[1]), .o_SM_Main(sm[1]), .o_Fifo_Count(fc1), .uart_clk_edge(edg[1]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[2]), .i_Tx_Byte(din8[2]),
    .o_Tx_Ready(rdy[2]), .o_Tx_Overflow(ovf[2]), .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]),
    .o_Tx_Done(done[2]), .o_SM_Main(sm[2]), .o_Fifo_Count(fc2), .uart_clk_edge(edg[2]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u3 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[3]), .i_Tx_Byte(din7),
    .o_Tx_Ready(rdy[3]), .o_Tx_Overflow(ovf[3]), .o_Tx_Active(act[3]), .o_Tx_Serial(ser[3]),
    .o_Tx_Done(done[3]), .o_SM_Main(sm[3]), .o_Fifo_Count(fc3), .uart_clk_edge(edg[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic write(input int inst, input logic [7:0] d);
    dv[inst] = 1'b1;
    if (inst == 3) din7 = d[6:0];
    else din8[inst] = d;
    step();
    dv[inst] = 1'b0;
  endtask

  task automatic find_start(input int inst, output int t0);
    for (int i = 0; i < 3000; i++) begin
      if (sm[inst] == 3'd1) break;
      step();
    end
    chk("start_seen", sm[inst], 3'd1);
    t0 = cyc;
  endtask

  // t0 is the edge at which the FSM entered START; line bit k is held after edges t0+1+CPB*k .. t0+CPB*(k+1).
  task automatic check_frame(input int inst, input logic [15:0] exp, input int nbits,
                             input int t0, input string tag);
    int e0, d0;
    e0 = edge_cnt[inst] + int'(edg[inst]);
    d0 = done_cnt[inst] + int'(done[inst]);
    wait_until(t0 + 1);
    chk({tag, "_start_low"}, ser[inst], 1'b0);
    chk({tag, "_active"}, act[inst], 1'b1);
    for (int k = 0; k < nbits; k++) begin
      wait_until(t0 + 1 + CPB * k + CPB / 2);
      chk($sformatf("%s_bit%0d", tag, k), ser[inst], exp[k]);
    end
    wait_until(t0 + CPB * nbits - 1);
    chk({tag, "_done_early"}, done[inst], 1'b0);
    step();
    chk({tag, "_done"}, done[inst], 1'b1);
    chk({tag, "_last_stop"}, ser[inst], 1'b1);
    chk({tag, "_edges"}, edge_cnt[inst] + int'(edg[inst]) - e0, nbits);
    chk({tag, "_done_count"}, done_cnt[inst] + int'(done[inst]) - d0, 1);
  endtask

  task automatic check_idle(input int inst, input string tag);
    step();
    chk({tag, "_sm_idle"}, sm[inst], 3'd0);
    chk({tag, "_line_high"}, ser[inst], 1'b1);
    chk({tag, "_inactive"}, act[inst], 1'b0);
  endtask

  initial begin
    int n, t0, t1, d0, o0;
    logic [15:0] ovf_exp [4];
    ovf_exp[0] = 16'b1000100000;  // 0x10
    ovf_exp[1] = 16'b1000100010;  // 0x11
    ovf_exp[2] = 16'b1000100100;  // 0x12
    ovf_exp[3] = 16'b1000100110;  // 0x13

    rst  = 1'b1;
    din7 = '0;
    for (int i = 0; i < 4; i++) dv[i] = 1'b0;
    for (int i = 0; i < 3; i++) din8[i] = '0;
    step(); step(); step();

    chk("rst_serial", ser[0], 1'b1);
    chk("rst_sm", sm[0], 3'd0);
    chk("rst_active", act[0], 1'b0);
    chk("rst_done", done[0], 1'b0);
    chk("rst_ovf", ovf[0], 1'b0);
    chk("rst_edge", edg[0], 1'b0);
    chk("rst_count", fc0, 3'd0);
    chk("rst_ready", rdy[0], 1'b1);
    chk("rst_serial_u3", ser[3], 1'b1);
    rst = 1'b0;
    step();

    // 8N1 0x61: line 0,1,0,0,0,0,1,1,0,1
    write(0, 8'h61);
    n = cyc;
    chk("lat_sm_still_idle", sm[0], 3'd0);
    chk("lat_count", fc0, 3'd1);
    chk("lat_line_high", ser[0], 1'b1);
    find_start(0, t0);
    chk("lat_start_edge", t0, n + 1);
    chk("lat_line_still_high", ser[0], 1'b1);
    check_frame(0, 16'b1011000010, 10, t0, "f61");
    check_idle(0, "f61");

    // Three consecutive writes chain into back-to-back frames.
    write(0, 8'h55);
    t0 = cyc + 1;
    write(0, 8'hAA);
    chk("b2b_count1", fc0, 3'd1);
    write(0, 8'h0F);
    chk("b2b_count_peak", fc0, 3'd2);
    chk("b2b_sm_start", sm[0], 3'd1);
    check_frame(0, 16'b1010101010, 10, t0, "b2b_55");
    find_start(0, t1);
    chk("b2b_gap1", t1 - t0, 870);
    check_frame(0, 16'b1101010100, 10, t1, "b2b_AA");
    find_start(0, t0);
    chk("b2b_gap2", t0 - t1, 870);
    check_frame(0, 16'b1000011110, 10, t0, "b2b_0F");
    check_idle(0, "b2b");

    // FIFO_DEPTH=4: line busy with 0x01, then 8 writes; only 0x10..0x13 fit.
    write(0, 8'h01);
    t0 = cyc + 1;
    step();
    chk("ovf_sm_start", sm[0], 3'd1);
    o0 = ovf_cnt[0] + int'(ovf[0]);
    for (int i = 0; i < 8; i++) begin
      write(0, 8'h10 + 8'(i));
      if (i == 2) chk("ovf_ready_3", rdy[0], 1'b1);
      if (i == 3) begin
        chk("ovf_ready_full", rdy[0], 1'b0);
        chk("ovf_count_full", fc0, 3'd4);
      end
    end
    chk("ovf_pulses", ovf_cnt[0] + int'(ovf[0]) - o0, 4);
    chk("ovf_count_hold", fc0, 3'd4);
    check_frame(0, 16'b1000000010, 10, t0, "ovf_01");
    for (int i = 0; i < 4; i++) begin
      find_start(0, t0);
      check_frame(0, ovf_exp[i], 10, t0, $sformatf("ovf_q%0d", i));
    end
    check_idle(0, "ovf");
    chk("ovf_count_empty", fc0, 3'd0);

    // Reset mid-DATA of 0x61 with two bytes queued.
    write(0, 8'h61);
    n = cyc;
    write(0, 8'hAA);
    write(0, 8'h0F);
    chk("mrst_queued", fc0, 3'd2);
    wait_until(n + 1 + CPB * 3 + 10);
    chk("mrst_in_data", sm[0], 3'd2);
    d0 = done_cnt[0] + int'(done[0]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_line_high", ser[0], 1'b1);
    chk("mrst_sm_idle", sm[0], 3'd0);
    chk("mrst_flushed", fc0, 3'd0);
    chk("mrst_ready", rdy[0], 1'b1);
    wait_until(cyc + 1000);
    chk("mrst_no_done", done_cnt[0] + int'(done[0]) - d0, 0);
    chk("mrst_stays_idle", sm[0], 3'd0);
    write(0, 8'h55);
    find_start(0, t0);
    check_frame(0, 16'b1010101010, 10, t0, "mrst_55");
    check_idle(0, "mrst");

    // Even parity 0x61: parity bit 1, 11 bits (957 cycles).
    write(1, 8'h61);
    find_start(1, t0);
    check_frame(1, 16'b11011000010, 11, t0, "even61");
    check_idle(1, "even61");

    // Odd parity 0x61: parity bit 0.
    write(2, 8'h61);
    find_start(2, t0);
    check_frame(2, 16'b10011000010, 11, t0, "odd61");
    check_idle(2, "odd61");

    // 7 data bits, 2 stop bits, 7'h41: last two bits high.
    write(3, 8'h41);
    find_start(3, t0);
    check_frame(3, 16'b1110000010, 10, t0, "d7s2");
    check_idle(3, "d7s2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
